armleocpu_ptw: RTL and testbench

- Sv32 hardware page-table walker on the TLB-miss path.
- When the TLB misses, the MMU control logic issues a resolve request here. The walker fetches PTEs from memory (at most 2 levels) and returns a 22-bit physical tag plus 8-bit PTE metadata.
- The result is formatted for the TLB new-entry inputs (ptag, metadata with bit0 = V). On failure it returns a page fault or access fault instead.

---
 rtl/armleocpu_ptw.sv | 185 ++++++++++++++++++
 tb/tb_armleocpu_ptw.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker. On a TLB miss it fetches up to two PTEs and returns
// a physical tag plus PTE metadata, or a page/access fault, as a one-cycle
// registered result pulse.
module armleocpu_ptw #(
    parameter logic ACCESSED_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_request,
    input  logic [19:0] resolve_vaddr,
    input  logic        satp_mode,
    input  logic [21:0] satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_ptag,
    output logic [7:0]  resolve_metadata,
    output logic        busy,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic        mem_done,
    input  logic        mem_error,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L0   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    // Only vpn0 is needed after the accept cycle: the root PPN and vpn1 are
    // consumed immediately into the registered L1 address, and the L1 PTE
    // PPN is consumed into the registered L0 address.
    logic [9:0]  vpn0_r;

    logic        done_r;
    logic        pagefault_r;
    logic        accessfault_r;
    logic [21:0] ptag_r;
    logic [7:0]  metadata_r;
    logic        busy_r;
    logic        mem_read_r;
    logic [33:0] mem_address_r;

    logic        accept_s;
    logic        load_s;
    logic        pf_s;
    logic        af_s;
    logic [21:0] ptag_s;
    logic [7:0]  meta_s;
    logic [33:0] addr_s;

    logic        pte_v_s;
    logic        pte_r_s;
    logic        pte_w_s;
    logic        pte_x_s;
    logic        pte_a_s;
    logic        unused_s;

    assign pte_v_s  = mem_readdata[0];
    assign pte_r_s  = mem_readdata[1];
    assign pte_w_s  = mem_readdata[2];
    assign pte_x_s  = mem_readdata[3];
    assign pte_a_s  = mem_readdata[6];
    // RSW bits carry no meaning for the walker.
    assign unused_s = &{1'b0, mem_readdata[9:8]};

    assign resolve_done        = done_r;
    assign resolve_pagefault   = pagefault_r;
    assign resolve_accessfault = accessfault_r;
    assign resolve_ptag        = ptag_r;
    assign resolve_metadata    = metadata_r;
    assign busy                = busy_r;
    assign mem_read            = mem_read_r;
    assign mem_address         = mem_address_r;

    // Next-state, PTE evaluation and next memory address for the walk.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        load_s       = 1'b0;
        pf_s         = 1'b0;
        af_s         = 1'b0;
        ptag_s       = 22'd0;
        meta_s       = 8'd0;
        addr_s       = mem_address_r;
        case (state_r)
            IDLE: begin
                if (resolve_request) begin
                    accept_s = 1'b1;
                    if (!satp_mode) begin
                        next_state_s = DONE;
                        load_s       = 1'b1;
                        ptag_s       = {2'b00, resolve_vaddr};
                        meta_s       = 8'hCF;
                    end else begin
                        next_state_s = L1;
                        addr_s       = {satp_ppn, resolve_vaddr[19:10], 2'b00};
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            L1, L0: begin
                if (mem_done) begin
                    if (mem_error) begin
                        next_state_s = DONE;
                        load_s       = 1'b1;
                        af_s         = 1'b1;
                    end else if (!pte_v_s || (!pte_r_s && pte_w_s)) begin
                        next_state_s = DONE;
                        load_s       = 1'b1;
                        pf_s         = 1'b1;
                    end else if (pte_r_s || pte_x_s) begin
                        next_state_s = DONE;
                        load_s       = 1'b1;
                        if ((ACCESSED_CHECK == 1'b1) && !pte_a_s) begin
                            pf_s = 1'b1;
                        end else if ((state_r == L1) && (mem_readdata[19:10] != 10'd0)) begin
                            pf_s = 1'b1;
                        end else if (state_r == L1) begin
                            ptag_s = {mem_readdata[31:20], vpn0_r};
                            meta_s = mem_readdata[7:0];
                        end else begin
                            ptag_s = mem_readdata[31:10];
                            meta_s = mem_readdata[7:0];
                        end
                    end else if (state_r == L1) begin
                        next_state_s = L0;
                        addr_s       = {mem_readdata[31:10], vpn0_r, 2'b00};
                    end else begin
                        next_state_s = DONE;
                        load_s       = 1'b1;
                        pf_s         = 1'b1;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, registered outputs derived from the next state, and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            vpn0_r        <= 10'd0;
            done_r        <= 1'b0;
            pagefault_r   <= 1'b0;
            accessfault_r <= 1'b0;
            ptag_r        <= 22'd0;
            metadata_r    <= 8'd0;
            busy_r        <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_address_r <= 34'd0;
        end else begin
            state_r       <= next_state_s;
            done_r        <= (next_state_s == DONE);
            busy_r        <= (next_state_s != IDLE);
            mem_read_r    <= (next_state_s == L1) || (next_state_s == L0);
            mem_address_r <= addr_s;
            if (accept_s) begin
                vpn0_r <= resolve_vaddr[9:0];
            end
            if (load_s) begin
                pagefault_r   <= pf_s;
                accessfault_r <= af_s;
                ptag_r        <= ptag_s;
                metadata_r    <= meta_s;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Scoreboard bench for the Sv32 page-table walker.
module tb_armleocpu_ptw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        resolve_request = 1'b0;
    logic [19:0] resolve_vaddr = 20'd0;
    logic        satp_mode = 1'b0;
    logic [21:0] satp_ppn = 22'd0;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_ptag;
    logic [7:0]  resolve_metadata;
    logic        busy;
    logic        mem_read;
    logic [33:0] mem_address;
    logic        mem_done = 1'b0;
    logic        mem_error = 1'b0;
    logic [31:0] mem_readdata = 32'd0;

    armleocpu_ptw dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .resolve_request     (resolve_request),
        .resolve_vaddr       (resolve_vaddr),
        .satp_mode           (satp_mode),
        .satp_ppn            (satp_ppn),
        .resolve_done        (resolve_done),
        .resolve_pagefault   (resolve_pagefault),
        .resolve_accessfault (resolve_accessfault),
        .resolve_ptag        (resolve_ptag),
        .resolve_metadata    (resolve_metadata),
        .busy                (busy),
        .mem_read            (mem_read),
        .mem_address         (mem_address),
        .mem_done            (mem_done),
        .mem_error           (mem_error),
        .mem_readdata        (mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pf;
        logic        af;
        logic [21:0] ptag;
        logic [7:0]  meta;
        logic        sv32;
    } exp_t;

    typedef struct {
        logic [33:0] addr;
        logic [31:0] data;
        logic        err;
        int          waits;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int asserts = 0;
    int failures = 0;
    int cyc = 0;
    int last_md_cyc = -100;
    logic prev_done = 1'b0;
    logic active = 1'b0;
    int   wcnt = 0;
    mem_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        asserts++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: serves queued PTE reads, checks address and its stability.
    always @(negedge clk) begin
        mem_done     = 1'b0;
        mem_error    = 1'b0;
        mem_readdata = 32'd0;
        if (!rst_n) begin
            active = 1'b0;
        end else if (mem_read) begin
            if (!active) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_read", 64'd1, 64'd0);
                end else begin
                    cur    = mem_q.pop_front();
                    active = 1'b1;
                    wcnt   = 0;
                    chk("mem_address", {30'd0, mem_address}, {30'd0, cur.addr});
                end
            end else begin
                chk("mem_address_stable", {30'd0, mem_address}, {30'd0, cur.addr});
            end
            if (active) begin
                if (wcnt == cur.waits) begin
                    mem_done     = 1'b1;
                    mem_error    = cur.err;
                    mem_readdata = cur.data;
                    active       = 1'b0;
                    last_md_cyc  = cyc;
                end else begin
                    // unqualified error and garbage data must be ignored
                    mem_error    = cur.err;
                    mem_readdata = $urandom;
                    wcnt++;
                end
            end
        end else begin
            // stray completion with no read outstanding must be ignored
            mem_done     = ((cyc % 7) == 3);
            mem_error    = 1'b1;
            mem_readdata = 32'h0EAF34CF;
        end
    end

    // Monitor: pops the expected result whenever the walker presents one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (resolve_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ptag", {42'd0, resolve_ptag}, {42'd0, e.ptag});
                    chk("metadata", {56'd0, resolve_metadata}, {56'd0, e.meta});
                    chk("pagefault", {63'd0, resolve_pagefault}, {63'd0, e.pf});
                    chk("accessfault", {63'd0, resolve_accessfault}, {63'd0, e.af});
                    if (e.sv32) begin
                        chk("done_latency", cyc, last_md_cyc + 1);
                    end
                end
                chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
            end
            prev_done = resolve_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic mem_push(input logic [33:0] a, input logic [31:0] d, input logic err, input int w);
        mem_t m;
        m.addr = a; m.data = d; m.err = err; m.waits = w;
        mem_q.push_back(m);
    endtask

    // Issue one request (called at a negedge), hold it until done is seen.
    task automatic walk(input logic mode, input logic [21:0] ppn, input logic [19:0] va,
                        input logic pf, input logic af, input logic [21:0] ptag, input logic [7:0] meta);
        exp_t e;
        logic got;
        e.pf = pf; e.af = af; e.ptag = ptag; e.meta = meta; e.sv32 = mode;
        exp_q.push_back(e);
        resolve_request = 1'b1;
        satp_mode       = mode;
        satp_ppn        = ppn;
        resolve_vaddr   = va;
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (resolve_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("walk_timeout", 64'd0, 64'd1);
        resolve_request = 1'b0;
        chk("mem_reads_consumed", mem_q.size(), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done", {63'd0, resolve_done}, 64'd0);
        chk("rst_pf", {63'd0, resolve_pagefault}, 64'd0);
        chk("rst_af", {63'd0, resolve_accessfault}, 64'd0);
        chk("rst_ptag", {42'd0, resolve_ptag}, 64'd0);
        chk("rst_meta", {56'd0, resolve_metadata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_address", {30'd0, mem_address}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // two-level walk, zero wait
        mem_push(34'h000100120, 32'h00080001, 1'b0, 0);
        mem_push(34'h000200D14, 32'h0EAF34CF, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b0, 1'b0, 22'h03ABCD, 8'hCF);
        // same walk with wait states at both levels
        mem_push(34'h000100120, 32'h00080001, 1'b0, 3);
        mem_push(34'h000200D14, 32'h0EAF34CF, 1'b0, 1);
        walk(1'b1, 22'h000100, 20'h12345, 1'b0, 1'b0, 22'h03ABCD, 8'hCF);
        // megapage: {PTE[31:20], vpn0} = {12'h001, 10'h345}
        mem_push(34'h000100120, 32'h001000CF, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b0, 1'b0, 22'h000745, 8'hCF);
        // misaligned megapage
        mem_push(34'h000100120, 32'h001004CF, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b1, 1'b0, 22'h0, 8'h0);
        // invalid PTE
        mem_push(34'h000100120, 32'h00000000, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b1, 1'b0, 22'h0, 8'h0);
        // W without R
        mem_push(34'h000100120, 32'h00000005, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b1, 1'b0, 22'h0, 8'h0);
        // leaf with A=0 at L0
        mem_push(34'h000100120, 32'h00080001, 1'b0, 0);
        mem_push(34'h000200D14, 32'h0EAF348F, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b1, 1'b0, 22'h0, 8'h0);
        // non-leaf at L0
        mem_push(34'h000100120, 32'h00080001, 1'b0, 0);
        mem_push(34'h000200D14, 32'h00080001, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b1, 1'b0, 22'h0, 8'h0);
        // bus error at L0 after 5 wait cycles
        mem_push(34'h000100120, 32'h00080001, 1'b0, 0);
        mem_push(34'h000200D14, 32'h0EAF34CF, 1'b1, 5);
        walk(1'b1, 22'h000100, 20'h12345, 1'b0, 1'b1, 22'h0, 8'h0);
        @(negedge clk);

        // bare mode with request held high: accept, done, idle, accept, done
        exp_q.push_back('{pf: 1'b0, af: 1'b0, ptag: 22'h0FFFFF, meta: 8'hCF, sv32: 1'b0});
        exp_q.push_back('{pf: 1'b0, af: 1'b0, ptag: 22'h0FFFFF, meta: 8'hCF, sv32: 1'b0});
        satp_mode = 1'b0; resolve_vaddr = 20'hFFFFF; resolve_request = 1'b1;
        @(negedge clk); chk("b2b_busy0", {63'd0, busy}, 64'd1);
        @(negedge clk); chk("b2b_busy1", {63'd0, busy}, 64'd0);
        @(negedge clk); chk("b2b_busy2", {63'd0, busy}, 64'd1);
        resolve_request = 1'b0;
        @(negedge clk); chk("b2b_busy3", {63'd0, busy}, 64'd0);
        @(negedge clk); chk("b2b_busy4", {63'd0, busy}, 64'd0);

        // reset while waiting in L0
        mem_push(34'h000100120, 32'h00080001, 1'b0, 0);
        mem_push(34'h000200D14, 32'h0EAF34CF, 1'b0, 50);
        satp_mode = 1'b1; satp_ppn = 22'h000100; resolve_vaddr = 20'h12345; resolve_request = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_read && (mem_address == 34'h000200D14)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_l0", {63'd0, seen}, 64'd1);
        #2 rst_n = 1'b0;
        resolve_request = 1'b0;
        #1;
        chk("midreset_mem_read", {63'd0, mem_read}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, resolve_done}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", {63'd0, busy}, 64'd0);

        // fresh walk after reset
        mem_push(34'h000100120, 32'h00080001, 1'b0, 2);
        mem_push(34'h000200D14, 32'h0EAF34CF, 1'b0, 0);
        walk(1'b1, 22'h000100, 20'h12345, 1'b0, 1'b0, 22'h03ABCD, 8'hCF);

        repeat (3) @(negedge clk);
        chk("results_held", {42'd0, resolve_ptag}, {42'd0, 22'h03ABCD});
        chk("exp_queue_empty", exp_q.size(), 64'd0);
        chk("mem_queue_empty", mem_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
